rcc_bdcr_ctrl: RTL and testbench
================================

RCC_BDCR_CTRL -- requirements
Module: rcc_bdcr_ctrl

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth for asynchronous status inputs.
REQ-002 SHALL have parameter LSE_TMO_CYCLES, default 4096: clk cycles allowed from LSEON set to LSERDY seen.
REQ-003 SHALL have one clock and an asynchronous active-low reset; clock and reset ports are as below.
REQ-004 clk  in  1  register clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset (backup-domain power-on).
REQ-006 dbp  in  1  write-protect disable; 0 = all writes ignored.
REQ-007 wr_en  in  1  single-cycle register write strobe.
REQ-008 wdata  in  32  write data.
REQ-009 rdata  out  32  current register image, combinational from state.
REQ-010 lse_rdy_async  in  1  LSE oscillator ready, asynchronous.
REQ-011 lsecss_fail_async  in  1  LSE CSS failure detect, asynchronous.
REQ-012 lseon, lsebyp, rtcen  out  1 each  oscillator enable, bypass and RTC kernel-clock enable.
REQ-013 rtcsel  out  2  RTC clock select (0 none, 1 LSE, 2 LSI, 3 HSE-RTC).
REQ-014 bdrst  out  1  software backup-domain reset.
REQ-015 lsecss_fail  out  1  sticky CSS failure flag, fed to the RTC clock switch.
REQ-016 irq  out  1  level interrupt = lsecssd | lse_tmo.

Function
REQ-017 Bit map: [0] LSEON, [1] LSERDY (RO), [2] LSEBYP, [5] LSECSSON, [6] LSECSSD (RO), [7] LSE_TMO (RO), [9:8] RTCSEL, [15] RTCEN, [16] BDRST; other rdata bits read 0.
REQ-018 Writes SHALL update state only when wr_en=1 and dbp=1, effective on the next clock edge.
REQ-019 LSERDY SHALL be lse_rdy_async through a SYNC_STAGES flop synchronizer.
REQ-020 LSEBYP SHALL be writable only while LSEON=0 and LSERDY=0; otherwise the old value is kept.
REQ-021 RTCSEL SHALL be write-once: writable only while RTCSEL==0; a non-zero value is locked until BDRST.
REQ-022 LSECSSON SHALL be settable only while LSEON=1 and LSERDY=1; writing 0 SHALL be ignored (cleared only by reset/BDRST).
REQ-023 LSECSSD SHALL set on the first cycle the synchronized lsecss_fail_async is 1 while LSECSSON=1, is sticky, and clears only by reset/BDRST.
REQ-024 lsecss_fail SHALL equal LSECSSD.
REQ-025 LSE FSM states: OFF, WAIT_RDY, RUN, TMO.
REQ-026 OFF->WAIT_RDY when LSEON becomes 1; the counter loads 0.
REQ-027 WAIT_RDY: counter increments per cycle; ->RUN when LSERDY=1; ->TMO when counter reaches LSE_TMO_CYCLES-1 with LSERDY=0; if LSERDY=1 in that same cycle, RUN wins.
REQ-028 TMO: LSE_TMO=1; ->RUN if LSERDY later rises, which clears LSE_TMO.
REQ-029 Any state ->OFF when LSEON=0; LSE_TMO clears; the counter saturates and never wraps.
REQ-030 While BDRST=1, all fields except BDRST SHALL be held at reset value, and writes to them in the same cycle as BDRST=1 SHALL be ignored.
REQ-031 Writing BDRST=0 SHALL release bdrst on the next edge; other fields are writable from the following write.

Reset
REQ-032 On rst_n=0, all outputs SHALL be 0, rdata SHALL be 0, synchronizers SHALL clear, the FSM SHALL be OFF and the counter 0.
REQ-033 Reset assertion mid-WAIT_RDY or with RTCSEL locked SHALL return to this state immediately; no state survives.

Structure
REQ-034 Bit positions, RTCSEL encodings and FSM state encoding SHALL live in the shared rcc package.
REQ-035 One sub-module SHALL be used: the existing multi-stage flop synchronizer, instantiated twice.

Verification
REQ-036 Reset, then dbp=0 with wdata=0x0000_8001 -> rdata stays 0x0.
REQ-037 dbp=1, write 0x1; lse_rdy_async rises at cycle 10 -> LSERDY=1 after 2 cycles, FSM RUN, LSE_TMO=0.
REQ-038 LSE_TMO_CYCLES=16, write LSEON with lse_rdy_async held at 0 -> LSE_TMO=1 and irq=1 at count 15; raising ready then clears both.
REQ-039 Write RTCSEL=1, then RTCSEL=2 -> reads 1; write BDRST=1, then 0, then RTCSEL=2 -> reads 2.
REQ-040 LSE running, write LSECSSON=1, pulse lsecss_fail_async -> LSECSSD=1, lsecss_fail=1 and irq=1; a later write of 0 to LSECSSON changes nothing; BDRST clears all.
REQ-041 Same-cycle write of 0x0001_8101 -> only bdrst=1; RTCEN, RTCSEL and LSEON stay 0.

Source files
------------

// File: rtl/rcc_bdcr_ctrl_pkg.sv
// Shared definitions for the backup-domain control register: bit map,
// RTC clock-select encodings and LSE supervisor state encoding.
package rcc_bdcr_ctrl_pkg;

  localparam int BIT_LSEON     = 0;
  localparam int BIT_LSERDY    = 1;
  localparam int BIT_LSEBYP    = 2;
  localparam int BIT_LSECSSON  = 5;
  localparam int BIT_LSECSSD   = 6;
  localparam int BIT_LSE_TMO   = 7;
  localparam int BIT_RTCSEL_LO = 8;
  localparam int BIT_RTCSEL_HI = 9;
  localparam int BIT_RTCEN     = 15;
  localparam int BIT_BDRST     = 16;

  typedef enum logic [1:0] {
    RTCSEL_NONE = 2'd0,
    RTCSEL_LSE  = 2'd1,
    RTCSEL_LSI  = 2'd2,
    RTCSEL_HSE  = 2'd3
  } rtcsel_e;

  typedef enum logic [1:0] {
    LSE_OFF      = 2'd0,
    LSE_WAIT_RDY = 2'd1,
    LSE_RUN      = 2'd2,
    LSE_TMO      = 2'd3
  } lse_state_e;

endpackage

// File: rtl/rcc_bdcr_ctrl_sync.sv
// Multi-stage flop synchronizer for a single asynchronous status bit.
module rcc_bdcr_ctrl_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '0;
    end else begin
      ff[0] <= d;
      for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/rcc_bdcr_ctrl.sv
// Backup-domain control register: LSE enable/bypass/CSS, write-once RTC
// clock select, software backup-domain reset and LSE startup supervisor.
module rcc_bdcr_ctrl
  import rcc_bdcr_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int LSE_TMO_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dbp,
  input  logic        wr_en,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        lse_rdy_async,
  input  logic        lsecss_fail_async,
  output logic        lseon,
  output logic        lsebyp,
  output logic        rtcen,
  output logic [1:0]  rtcsel,
  output logic        bdrst,
  output logic        lsecss_fail,
  output logic        irq,
  output lse_state_e  lse_state
);

  localparam int CW = (LSE_TMO_CYCLES > 2) ? $clog2(LSE_TMO_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LSE_TMO_CYCLES - 1);

  logic lserdy, css_sync;
  logic lsecsson, lsecssd;
  logic we, clr;
  logic [CW-1:0] cnt, cnt_nxt;
  lse_state_e state, state_nxt;
  logic unused_wdata;

  rcc_bdcr_ctrl_sync #(.STAGES(SYNC_STAGES)) u_sync_rdy (
    .clk(clk), .rst_n(rst_n), .d(lse_rdy_async), .q(lserdy)
  );

  rcc_bdcr_ctrl_sync #(.STAGES(SYNC_STAGES)) u_sync_css (
    .clk(clk), .rst_n(rst_n), .d(lsecss_fail_async), .q(css_sync)
  );

  // wr_en is a one-cycle strobe with no back-pressure; dbp gates it.
  // clr covers both a held BDRST and the write that sets it.
  assign we  = wr_en & dbp;
  assign clr = bdrst | (we & wdata[BIT_BDRST]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lseon    <= 1'b0;
      lsebyp   <= 1'b0;
      lsecsson <= 1'b0;
      lsecssd  <= 1'b0;
      rtcsel   <= RTCSEL_NONE;
      rtcen    <= 1'b0;
      bdrst    <= 1'b0;
    end else begin
      if (we) bdrst <= wdata[BIT_BDRST];
      if (clr) begin
        lseon    <= 1'b0;
        lsebyp   <= 1'b0;
        lsecsson <= 1'b0;
        lsecssd  <= 1'b0;
        rtcsel   <= RTCSEL_NONE;
        rtcen    <= 1'b0;
      end else begin
        if (lsecsson && css_sync) lsecssd <= 1'b1;
        if (we) begin
          lseon <= wdata[BIT_LSEON];
          rtcen <= wdata[BIT_RTCEN];
          if (!lseon && !lserdy) lsebyp <= wdata[BIT_LSEBYP];
          if (wdata[BIT_LSECSSON] && lseon && lserdy) lsecsson <= 1'b1;
          if (rtcsel == RTCSEL_NONE) rtcsel <= wdata[BIT_RTCSEL_HI:BIT_RTCSEL_LO];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LSE_OFF;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Counter stops at CNT_LAST because WAIT_RDY leaves for TMO there.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (clr || !lseon) begin
      state_nxt = LSE_OFF;
      cnt_nxt   = '0;
    end else begin
      case (state)
        LSE_OFF: begin
          state_nxt = LSE_WAIT_RDY;
          cnt_nxt   = '0;
        end
        LSE_WAIT_RDY: begin
          if (lserdy)                state_nxt = LSE_RUN;
          else if (cnt == CNT_LAST)  state_nxt = LSE_TMO;
          else                       cnt_nxt   = cnt + 1'b1;
        end
        LSE_TMO: if (lserdy) state_nxt = LSE_RUN;
        LSE_RUN: state_nxt = LSE_RUN;
        default: state_nxt = LSE_OFF;
      endcase
    end
  end

  assign lse_state   = state;
  assign lsecss_fail = lsecssd;
  assign irq         = lsecssd | (state == LSE_TMO);

  always_comb begin
    rdata                              = '0;
    rdata[BIT_LSEON]                   = lseon;
    rdata[BIT_LSERDY]                  = lserdy & ~bdrst;
    rdata[BIT_LSEBYP]                  = lsebyp;
    rdata[BIT_LSECSSON]                = lsecsson;
    rdata[BIT_LSECSSD]                 = lsecssd;
    rdata[BIT_LSE_TMO]                 = (state == LSE_TMO);
    rdata[BIT_RTCSEL_HI:BIT_RTCSEL_LO] = rtcsel;
    rdata[BIT_RTCEN]                   = rtcen;
    rdata[BIT_BDRST]                   = bdrst;
  end

  assign unused_wdata = ^{wdata[31:17], wdata[14:10], wdata[7:6], wdata[4:3], wdata[1]};

endmodule

// File: tb/tb_rcc_bdcr_ctrl.sv
// Directed bench for rcc_bdcr_ctrl: history-based reference model checked
// every cycle, plus hand-computed readback pins.
module tb_rcc_bdcr_ctrl;
  import rcc_bdcr_ctrl_pkg::*;

  localparam int S = 2;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dbp = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wdata = '0;
  logic        lse_rdy_async = 1'b0;
  logic        lsecss_fail_async = 1'b0;
  logic [31:0] rdata;
  logic        lseon, lsebyp, rtcen, bdrst, lsecss_fail, irq;
  logic [1:0]  rtcsel;
  lse_state_e  lse_state;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  logic [31:0] exp_q[$];

  rcc_bdcr_ctrl #(.SYNC_STAGES(S), .LSE_TMO_CYCLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .dbp(dbp), .wr_en(wr_en), .wdata(wdata),
    .rdata(rdata), .lse_rdy_async(lse_rdy_async),
    .lsecss_fail_async(lsecss_fail_async), .lseon(lseon), .lsebyp(lsebyp),
    .rtcen(rtcen), .rtcsel(rtcsel), .bdrst(bdrst), .lsecss_fail(lsecss_fail),
    .irq(irq), .lse_state(lse_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // age: edges elapsed with LSEON already set (-1 when off); ran: ready seen since.
  bit         m_lseon, m_byp, m_csson, m_cssd, m_rtcen, m_bdrst;
  logic [1:0] m_rtcsel;
  bit [S-1:0] m_rdy_h, m_css_h;
  int         age = -1;
  bit         ran;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_lseon = 0; m_byp = 0; m_csson = 0; m_cssd = 0; m_rtcen = 0; m_bdrst = 0;
      m_rtcsel = 2'd0; m_rdy_h = '0; m_css_h = '0; age = -1; ran = 0;
    end else begin
      bit we, clr, rdy_s, css_s;
      we    = wr_en && dbp;
      clr   = m_bdrst || (we && wdata[16]);
      rdy_s = m_rdy_h[S-1];
      css_s = m_css_h[S-1];
      if (clr || !m_lseon) begin
        age = -1; ran = 0;
      end else begin
        if (age >= 0 && rdy_s) ran = 1;
        if (age < 100000) age++;
      end
      if (clr) begin
        m_lseon = 0; m_byp = 0; m_csson = 0; m_cssd = 0; m_rtcen = 0; m_rtcsel = 2'd0;
      end else begin
        if (m_csson && css_s) m_cssd = 1;
        if (we) begin
          if (!m_lseon && !rdy_s) m_byp = wdata[2];
          if (wdata[5] && m_lseon && rdy_s) m_csson = 1;
          if (m_rtcsel == 2'd0) m_rtcsel = wdata[9:8];
          m_rtcen = wdata[15];
          m_lseon = wdata[0];
        end
      end
      if (we) m_bdrst = wdata[16];
      m_rdy_h = {m_rdy_h[S-2:0], lse_rdy_async};
      m_css_h = {m_css_h[S-2:0], lsecss_fail_async};
    end
  end

  function automatic bit exp_tmo();
    return (age >= N) && !ran;
  endfunction

  function automatic lse_state_e exp_state();
    if (age < 0)   return LSE_OFF;
    if (ran)       return LSE_RUN;
    if (exp_tmo()) return LSE_TMO;
    return LSE_WAIT_RDY;
  endfunction

  function automatic logic [31:0] exp_rdata();
    logic [31:0] r;
    r = '0;
    r[0] = m_lseon;
    r[1] = m_rdy_h[S-1] & ~m_bdrst;
    r[2] = m_byp;
    r[5] = m_csson;
    r[6] = m_cssd;
    r[7] = exp_tmo();
    r[9:8] = m_rtcsel;
    r[15] = m_rtcen;
    r[16] = m_bdrst;
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pin(input string name, input logic [31:0] exp);
    exp_q.push_back(exp);
    chk(name, rdata, exp_q.pop_front());
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("rdata",       rdata,               exp_rdata());
      chk("lseon",       32'(lseon),          32'(m_lseon));
      chk("lsebyp",      32'(lsebyp),         32'(m_byp));
      chk("rtcen",       32'(rtcen),          32'(m_rtcen));
      chk("rtcsel",      32'(rtcsel),         32'(m_rtcsel));
      chk("bdrst",       32'(bdrst),          32'(m_bdrst));
      chk("lsecss_fail", 32'(lsecss_fail),    32'(m_cssd));
      chk("irq",         32'(irq),            32'(m_cssd | exp_tmo()));
      chk("lse_state",   32'(lse_state),      32'(exp_state()));
    end
  end

  // ---------------- driver ----------------
  task automatic wr(input logic [31:0] d);
    @(negedge clk);
    wr_en = 1'b1;
    wdata = d;
    @(negedge clk);
    wr_en = 1'b0;
    wdata = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    idle(3);
    chk_en = 1'b1;
    pin("reset_rdata", 32'h0);
    chk("reset_state", 32'(lse_state), 32'(LSE_OFF));
    rst_n = 1'b1;

    // write protect
    wr(32'h0000_8001);
    idle(1);
    pin("dbp0_ignored", 32'h0);
    dbp = 1'b1;

    // LSE start with ready
    wr(32'h1);
    pin("lseon_set", 32'h1);
    idle(8);
    lse_rdy_async = 1'b1;
    idle(3);
    pin("lse_ready", 32'h3);
    chk("lse_run", 32'(lse_state), 32'(LSE_RUN));
    wr(32'h5);
    pin("byp_locked", 32'h3);

    // CSS
    wr(32'h21);
    pin("csson_set", 32'h23);
    @(negedge clk);
    lsecss_fail_async = 1'b1;
    @(negedge clk);
    lsecss_fail_async = 1'b0;
    idle(2);
    pin("cssd_set", 32'h63);
    chk("css_fail_out", 32'(lsecss_fail), 32'd1);
    chk("css_irq", 32'(irq), 32'd1);
    wr(32'h1);
    pin("csson_no_clear", 32'h63);
    wr(32'h1_0000);
    pin("bdrst_clears", 32'h1_0000);
    chk("bdrst_irq", 32'(irq), 32'd0);
    wr(32'h1_0021);
    pin("bdrst_hold", 32'h1_0000);
    wr(32'h0);
    pin("bdrst_release", 32'h2);
    lse_rdy_async = 1'b0;
    idle(3);
    pin("rdy_dropped", 32'h0);

    // RTCSEL write-once
    wr(32'h100);
    pin("rtcsel_lse", 32'h100);
    wr(32'h200);
    pin("rtcsel_locked", 32'h100);
    wr(32'h1_0000);
    pin("rtcsel_bdrst", 32'h1_0000);
    wr(32'h0);
    pin("rtcsel_released", 32'h0);
    wr(32'h200);
    pin("rtcsel_lsi", 32'h200);

    // same-cycle write with BDRST
    wr(32'h1_8101);
    pin("bdrst_same_cycle", 32'h1_0000);
    chk("same_rtcen", 32'(rtcen), 32'd0);
    chk("same_rtcsel", 32'(rtcsel), 32'd0);
    chk("same_lseon", 32'(lseon), 32'd0);
    wr(32'h0);
    pin("after_bdrst", 32'h0);

    // bypass writable while off and not ready
    wr(32'h4);
    pin("byp_set", 32'h4);

    // timeout: TMO appears at the edge where the count is 15
    wr(32'h1);
    pin("tmo_start", 32'h1);
    idle(16);
    pin("tmo_not_yet", 32'h1);
    idle(1);
    pin("tmo_set", 32'h81);
    chk("tmo_irq", 32'(irq), 32'd1);
    chk("tmo_state", 32'(lse_state), 32'(LSE_TMO));
    lse_rdy_async = 1'b1;
    idle(3);
    pin("tmo_recover", 32'h3);
    chk("tmo_irq_clr", 32'(irq), 32'd0);

    // ready arriving on the terminal count: RUN wins
    wr(32'h0);
    pin("lse_off", 32'h2);
    lse_rdy_async = 1'b0;
    idle(3);
    wr(32'h1);
    idle(14);
    lse_rdy_async = 1'b1;
    idle(3);
    chk("edge_run_wins", 32'(lse_state), 32'(LSE_RUN));
    pin("edge_rdata", 32'h3);

    // power-on reset mid WAIT_RDY with RTCSEL locked
    wr(32'h0);
    lse_rdy_async = 1'b0;
    idle(3);
    wr(32'h101);
    pin("pre_por", 32'h101);
    idle(4);
    #3;
    rst_n = 1'b0;
    #1;
    pin("por_rdata", 32'h0);
    chk("por_state", 32'(lse_state), 32'(LSE_OFF));
    chk("por_rtcsel", 32'(rtcsel), 32'd0);
    chk("por_lseon", 32'(lseon), 32'd0);
    idle(2);
    rst_n = 1'b1;
    wr(32'h200);
    pin("rtcsel_after_por", 32'h200);

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
